frame_param_sched: RTL and testbench

//  Sequences triangle/light/view-projection parameter updates from the UART

---
 rtl/frame_param_sched.sv | 188 ++++++++++++++++++
 tb/tb_frame_param_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_param_sched.sv
// Frame-synchronous parameter scheduler: assembles IA bytes into a shadow buffer and
// commits a complete packet to the VS bus at frame_start. Optional macro: PARAM_CHECKSUM_EN.
module frame_param_sched #(
    parameter int NUM_WORDS   = 27,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    input  logic                     pkt_done,
    input  logic                     frame_start,
    output logic [NUM_WORDS*16-1:0]  params_out,
    output logic                     params_valid,
    output logic                     vs_start,
    output logic                     busy,
    output logic                     err_drop,
    output logic [1:0]               dbg_state
);

    localparam int NUM_BYTES = 2 * NUM_WORDS;
`ifdef PARAM_CHECKSUM_EN
    localparam int EXP_BYTES = NUM_BYTES + 1;
`else
    localparam int EXP_BYTES = NUM_BYTES;
`endif
    localparam int PW = $clog2(EXP_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] EXP_PTR = PW'(EXP_BYTES);
    localparam logic [PW-1:0] NB_PTR  = PW'(NUM_BYTES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_PENDING = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic [TW-1:0]             idle_q, idle_d;
    logic                      err_q, err_d;
    logic                      vs_q, vs_d;
    logic                      valid_q, valid_d;
    logic [NUM_WORDS*16-1:0]   params_q;
    logic [7:0]                shadow_q [NUM_BYTES];
    logic [NUM_WORDS*16-1:0]   shadow_flat;
    logic                      byte_store;
    logic                      wr_en;
    logic                      commit;
    logic                      csum_ok;

    // A byte is accepted only while assembling and only if the packet has room for it;
    // in IDLE the pointer is always 0, so the first byte lands at slot 0.
    assign byte_store = byte_valid && (state_q != S_PENDING) && (ptr_q < EXP_PTR);
    assign wr_en      = byte_store && (ptr_q < NB_PTR);

`ifdef PARAM_CHECKSUM_EN
    logic [7:0] xor_q, xor_d, chk_q, chk_d;

    always_comb begin
        xor_d = xor_q;
        chk_d = chk_q;
        if (byte_store) begin
            if (ptr_q == '0)
                xor_d = byte_data;
            else if (ptr_q < NB_PTR)
                xor_d = xor_q ^ byte_data;
            else
                chk_d = byte_data;
        end
        // Uses the next values so a byte arriving with pkt_done is included.
        csum_ok = (xor_d == chk_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q <= '0;
            chk_q <= '0;
        end else begin
            xor_q <= xor_d;
            chk_q <= chk_d;
        end
    end
`else
    assign csum_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idle_d  = idle_q;
        err_d   = 1'b0;
        vs_d    = 1'b0;
        valid_d = valid_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE, S_FILL: begin
                if (byte_valid) begin
                    idle_d = '0;
                    if (byte_store)
                        ptr_d = ptr_q + PW'(1);
                    else
                        err_d = 1'b1;
                    if (state_q == S_IDLE)
                        state_d = S_FILL;
                end
                // pkt_done in IDLE counts only when a byte opened the packet this cycle.
                if (pkt_done && ((state_q == S_FILL) || byte_valid)) begin
                    if ((ptr_d == EXP_PTR) && csum_ok) begin
                        state_d = S_PENDING;
                    end else begin
                        err_d   = 1'b1;
                        ptr_d   = '0;
                        state_d = S_IDLE;
                    end
                end else if ((state_q == S_FILL) && !byte_valid) begin
                    if (idle_q == TO_LAST) begin
                        err_d   = 1'b1;
                        ptr_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
                end
            end
            S_PENDING: begin
                if (byte_valid)
                    err_d = 1'b1;
                if (frame_start) begin
                    commit  = 1'b1;
                    valid_d = 1'b1;
                    vs_d    = 1'b1;
                    ptr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ptr_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < NUM_BYTES; i++)
            shadow_flat[8*i +: 8] = shadow_q[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BYTES; i++)
                shadow_q[i] <= '0;
        end else if (wr_en) begin
            shadow_q[ptr_q] <= byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            idle_q   <= '0;
            err_q    <= 1'b0;
            vs_q     <= 1'b0;
            valid_q  <= 1'b0;
            params_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            vs_q    <= vs_d;
            valid_q <= valid_d;
            if (commit)
                params_q <= shadow_flat;
        end
    end

    assign params_out   = params_q;
    assign params_valid = valid_q;
    assign vs_start     = vs_q;
    assign busy         = (state_q != S_IDLE);
    assign err_drop     = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_frame_param_sched.sv
// Directed bench for frame_param_sched: packet commit, drops, timeout, coincident
// events and reset while pending.
module tb_frame_param_sched;

    localparam int NW = 27;
    localparam int NB = 2 * NW;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            byte_valid = 1'b0;
    logic [7:0]      byte_data = '0;
    logic            pkt_done = 1'b0;
    logic            frame_start = 1'b0;
    logic [NW*16-1:0] params_out;
    logic            params_valid;
    logic            vs_start;
    logic            busy;
    logic            err_drop;
    logic [1:0]      dbg_state;

    int n_total = 0;
    int n_pass  = 0;

    logic [NW*16-1:0] exp_cur;

    frame_param_sched #(.NUM_WORDS(NW), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .pkt_done     (pkt_done),
        .frame_start  (frame_start),
        .params_out   (params_out),
        .params_valid (params_valid),
        .vs_start     (vs_start),
        .busy         (busy),
        .err_drop     (err_drop),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++)
            send_byte(base + 8'(i));
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] base);
        logic [7:0] x = '0;
        for (int i = 0; i < NB; i++)
            x = x ^ (base + 8'(i));
        return x;
    endfunction

    // Full-length packet, plus the trailing check byte when the checksum build is used.
    task automatic send_full(input logic [7:0] base);
        send_bytes(base, NB);
`ifdef PARAM_CHECKSUM_EN
        send_byte(xor_of(base));
`endif
    endtask

    task automatic pulse_pkt_done();
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    function automatic logic [NW*16-1:0] exp_params(input logic [7:0] base);
        logic [NW*16-1:0] r = '0;
        for (int i = 0; i < NB; i++)
            r[8*i +: 8] = base + 8'(i);
        return r;
    endfunction

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_params", params_out, '0);
        check("rst_valid", params_valid, 0);
        check("rst_vs", vs_start, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_drop, 0);
        check("rst_state", dbg_state, 0);

        // pkt_done with no packet open is ignored
        pulse_pkt_done();
        check("idle_pkt_err", err_drop, 0);
        check("idle_pkt_busy", busy, 0);

        // Test 1: bytes 0x00..0x35, pkt_done, frame_start
        send_full(8'h00);
        check("t1_busy_fill", busy, 1);
        pulse_pkt_done();
        check("t1_pending", dbg_state, 2);
        check("t1_no_err", err_drop, 0);
        tick();
        check("t1_no_vs_yet", vs_start, 0);
        check("t1_params_old", params_out, '0);
        pulse_frame();
        check("t1_vs", vs_start, 1);
        check("t1_valid", params_valid, 1);
        check("t1_word0", params_out[15:0], 16'h0100);
        check("t1_word26", params_out[431:416], 16'h3534);
        check("t1_params", params_out, exp_params(8'h00));
        check("t1_idle", busy, 0);
        tick();
        check("t1_vs_one_cycle", vs_start, 0);
        exp_cur = exp_params(8'h00);

        // Test 2: short packet dropped, then a normal one commits
        send_bytes(8'h80, NB - 1);
        pulse_pkt_done();
        check("t2_err", err_drop, 1);
        check("t2_busy", busy, 0);
        check("t2_params_kept", params_out, exp_cur);
        tick();
        check("t2_err_pulse", err_drop, 0);
        send_full(8'h40);
        pulse_pkt_done();
        pulse_frame();
        check("t2_vs", vs_start, 1);
        check("t2_params", params_out, exp_params(8'h40));
        exp_cur = exp_params(8'h40);

        // Test 3: timeout after TO idle cycles
        send_bytes(8'h11, 10);
        for (int i = 0; i < TO - 1; i++)
            tick();
        check("t3_no_err_early", err_drop, 0);
        check("t3_still_fill", dbg_state, 1);
        tick();
        check("t3_err", err_drop, 1);
        check("t3_state", dbg_state, 0);
        tick();
        check("t3_err_pulse", err_drop, 0);
        check("t3_params_kept", params_out, exp_cur);

        // Test 4: byte while pending is dropped, commit excludes it
        send_full(8'h10);
        pulse_pkt_done();
        send_byte(8'hAA);
        check("t4_err", err_drop, 1);
        check("t4_pending", dbg_state, 2);
        pulse_frame();
        check("t4_err_clear", err_drop, 0);
        check("t4_vs", vs_start, 1);
        check("t4_params", params_out, exp_params(8'h10));
        exp_cur = exp_params(8'h10);

        // Test 5: pkt_done with frame_start does not commit yet
        send_full(8'h20);
        pkt_done    = 1'b1;
        frame_start = 1'b1;
        tick();
        pkt_done    = 1'b0;
        frame_start = 1'b0;
        check("t5_no_vs", vs_start, 0);
        check("t5_pending", dbg_state, 2);
        check("t5_params_kept", params_out, exp_cur);
        tick();
        check("t5_still_no_vs", vs_start, 0);
        pulse_frame();
        check("t5_vs", vs_start, 1);
        check("t5_params", params_out, exp_params(8'h20));

        // Overflow byte in FILL is dropped, packet still completes
        send_full(8'h60);
        send_byte(8'hEE);
        check("ovf_err", err_drop, 1);
        check("ovf_state", dbg_state, 1);
        pulse_pkt_done();
        check("ovf_pending", dbg_state, 2);
        pulse_frame();
        check("ovf_params", params_out, exp_params(8'h60));

        // Last byte coincident with pkt_done is counted
        send_bytes(8'h30, NB - 1);
`ifdef PARAM_CHECKSUM_EN
        send_byte(8'h30 + 8'(NB - 1));
        byte_data = xor_of(8'h30);
`else
        byte_data = 8'h30 + 8'(NB - 1);
`endif
        byte_valid = 1'b1;
        pkt_done   = 1'b1;
        tick();
        byte_valid = 1'b0;
        pkt_done   = 1'b0;
        check("coinc_pending", dbg_state, 2);
        check("coinc_no_err", err_drop, 0);
        pulse_frame();
        check("coinc_params", params_out, exp_params(8'h30));
        exp_cur = exp_params(8'h30);

`ifdef PARAM_CHECKSUM_EN
        send_bytes(8'h70, NB);
        send_byte(xor_of(8'h70) ^ 8'h01);
        pulse_pkt_done();
        check("cs_bad_err", err_drop, 1);
        check("cs_bad_idle", busy, 0);
        pulse_frame();
        check("cs_bad_no_vs", vs_start, 0);
        check("cs_bad_params", params_out, exp_cur);
`endif

        // Reset while pending discards everything
        send_full(8'h50);
        pulse_pkt_done();
        check("rp_pending", dbg_state, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rp_params", params_out, '0);
        check("rp_valid", params_valid, 0);
        check("rp_busy", busy, 0);
        pulse_frame();
        check("rp_no_vs", vs_start, 0);
        check("rp_params_after", params_out, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
